// File: rtl/my_design_deser_if.sv
// my_design_deser_if: parallel output port of the deserializer (valid/ready word plus parity flag)
//   dout       word, bit 0 is the first bit received
//   dout_valid dout holds an unconsumed word
//   dout_ready consumer accepts dout when dout_valid & dout_ready
//   par_err    parity mismatch for the word on dout, qualified by dout_valid
interface my_design_deser_if #(parameter int WIDTH = 3);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             par_err;
    modport master (output dout, output dout_valid, output par_err, input dout_ready);
    modport slave (input dout, input dout_valid, input par_err, output dout_ready);
endinterface

// File: rtl/my_design_deser.sv
// my_design_deser: framed serial-to-parallel receiver with optional even parity
//   clk, rst   rising-edge clock, synchronous active-high reset
//   sin        serial data, idles at 0; start bit is a sampled 1
//   sin_en     bit strobe; sin is sampled only when high
//   bus        master side of my_design_deser_if (dout/dout_valid/par_err out, dout_ready in)
//   overrun    sticky, a completed frame was dropped because dout was still held
//   frame_cnt  words loaded into dout, modulo 256
module my_design_deser #(
    parameter int WIDTH = 3,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sin,
    input  logic                sin_en,
    my_design_deser_if.master   bus,
    output logic                overrun,
    output logic [7:0]          frame_cnt
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
    state_t           state;
    logic [CW-1:0]    bitcnt;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] nsr;
    logic [WIDTH-1:0] word;
    logic             last;
    logic             done;
    logic             err;
    always_comb begin
        last = state == DATA && bitcnt == CW'(WIDTH - 1);
        done = sin_en && (state == PAR || (last && !PARITY_EN));
        // sr is cleared at the start bit, so OR-ing places each bit at its position
        nsr  = sr | (WIDTH'(sin) << bitcnt);
        // without parity the last data bit is still in flight, so take it from nsr
        word = state == PAR ? sr : nsr;
        err  = PARITY_EN && state == PAR && ((^sr) ^ sin);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bitcnt         <= '0;
            sr             <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            overrun        <= 1'b0;
            frame_cnt      <= '0;
        end else begin
            if (sin_en) begin
                case (state)
                    IDLE: if (sin) begin
                        state  <= DATA;
                        bitcnt <= '0;
                        sr     <= '0;
                    end
                    DATA: begin
                        sr     <= nsr;
                        bitcnt <= last ? bitcnt : bitcnt + 1'b1;
                        state  <= last ? (PARITY_EN ? PAR : IDLE) : DATA;
                    end
                    default: state <= IDLE;
                endcase
            end
            // a completing frame takes priority over a plain handshake; it is
            // dropped only when the held word is not being consumed this edge
            if (done) begin
                if (!bus.dout_valid || bus.dout_ready) begin
                    bus.dout       <= word;
                    bus.par_err    <= err;
                    bus.dout_valid <= 1'b1;
                    frame_cnt      <= frame_cnt + 8'd1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (bus.dout_valid && bus.dout_ready) begin
                bus.dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_my_design_deser.sv
// tb_my_design_deser: directed self-checking bench for my_design_deser (WIDTH=3, PARITY_EN=1)
module tb_my_design_deser;
    logic       clk = 1'b0;
    logic       rst;
    logic       sin;
    logic       sin_en;
    logic       overrun;
    logic [7:0] frame_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;
    my_design_deser_if #(.WIDTH(3)) bus ();
    my_design_deser #(.WIDTH(3), .PARITY_EN(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .sin(sin),
        .sin_en(sin_en),
        .bus(bus),
        .overrun(overrun),
        .frame_cnt(frame_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send_bit(input logic b, input logic en);
        sin    = b;
        sin_en = en;
        tick();
    endtask
    task automatic send_frame(input logic [2:0] d, input logic p);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(d[i], 1'b1);
        send_bit(p, 1'b1);
        sin    = 1'b0;
        sin_en = 1'b0;
    endtask
    task automatic do_reset();
        rst    = 1'b1;
        sin    = 1'b0;
        sin_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask
    task automatic chk_out(input string tag, input logic [2:0] d, input logic v, input logic pe,
                           input logic ov, input logic [7:0] cnt);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
        chk({tag, ".valid"}, 32'(bus.dout_valid), 32'(v));
        chk({tag, ".par_err"}, 32'(bus.par_err), 32'(pe));
        chk({tag, ".overrun"}, 32'(overrun), 32'(ov));
        chk({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(cnt));
    endtask
    initial begin
        logic [2:0] d;
        bus.dout_ready = 1'b0;
        do_reset();
        tick();
        chk_out("reset", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0);
        // 101 with correct parity; valid must not rise before the parity edge
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        chk("good.early_valid", 32'(bus.dout_valid), 32'd0);
        send_bit(1'b0, 1'b1);
        sin_en = 1'b0;
        chk_out("good", 3'b101, 1'b1, 1'b0, 1'b0, 8'd1);
        // handshake during an sin_en gap still clears valid
        bus.dout_ready = 1'b1;
        tick();
        chk("good.consumed", 32'(bus.dout_valid), 32'd0);
        bus.dout_ready = 1'b0;
        // same data with wrong parity bit
        do_reset();
        send_frame(3'b101, 1'b1);
        chk_out("bad_par", 3'b101, 1'b1, 1'b1, 1'b0, 8'd1);
        // overrun: two back-to-back frames with no consumer
        do_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_frame(3'b110, 1'b0);
        chk_out("overrun", 3'b011, 1'b1, 1'b0, 1'b1, 8'd1);
        bus.dout_ready = 1'b1;
        tick();
        chk("overrun.consumed", 32'(bus.dout_valid), 32'd0);
        chk("overrun.sticky", 32'(overrun), 32'd1);
        // 300 back-to-back frames with ready held high; count wraps to 44
        do_reset();
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            d = 3'($urandom_range(0, 7));
            send_frame(d, ^d);
            chk("stream.dout", 32'(bus.dout), 32'(d));
            chk("stream.par_err", 32'(bus.par_err), 32'd0);
            chk("stream.valid", 32'(bus.dout_valid), 32'd1);
        end
        chk("stream.frame_cnt", 32'(frame_cnt), 32'd44);
        chk("stream.overrun", 32'(overrun), 32'd0);
        // 010 with two unsampled edges after each bit (garbage on sin during gaps)
        do_reset();
        bus.dout_ready = 1'b0;
        d = 3'b010;
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(d[i], 1'b1);
            send_bit(~d[i], 1'b0);
            send_bit(~d[i], 1'b0);
        end
        chk("gaps.early_valid", 32'(bus.dout_valid), 32'd0);
        send_bit(1'b1, 1'b1);
        sin_en = 1'b0;
        chk_out("gaps", 3'b010, 1'b1, 1'b0, 1'b0, 8'd1);
        // reset in mid-frame discards the partial frame
        do_reset();
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        sin_en = 1'b0;
        chk_out("mid_rst", 3'b000, 1'b0, 1'b0, 1'b0, 8'd0);
        send_frame(3'b111, 1'b1);
        chk_out("after_rst", 3'b111, 1'b1, 1'b0, 1'b0, 8'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/my_design_deser.md
# my_design_deser

Serial-to-parallel deserializer: the receiving end of a one-wire framed bitstream that carries a small parallel word such as the three-bit {z, y, x} group feeding the design's sub-blocks. It detects a start bit, shifts in WIDTH data bits LSB first, and checks an optional even-parity bit. It presents each completed word on a valid/ready output port and flags parity errors and overruns. It sits between the serial link and any parallel consumer in the test designs.

## Interface

- WIDTH, default 3: data bits per frame; legal range 2..16.
- PARITY_EN, default 1: 1 = one even-parity bit follows the data; 0 = no parity bit.

- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sin  input  1  serial data; line idles at 0.
- sin_en  input  1  bit strobe; sin is sampled only on edges where sin_en=1.
- dout  output  WIDTH  received word; dout[0] is the first data bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready.
- par_err  output  1  parity mismatch for the word currently on dout; qualified by dout_valid.
- overrun  output  1  sticky; a completed frame was dropped.
- frame_cnt  output  8  count of words delivered to dout; wraps modulo 256.

## Operation

- All state changes occur only on sampled bits (sin_en=1), except the output handshake and reset.
- FSM states:
  - IDLE: sampled sin=1 → DATA with bit counter 0. Sampled sin=0 → stay in IDLE.
  - DATA: each sampled bit is shifted into position bitcnt of the shift register.
    - After bit WIDTH-1: go to PAR if PARITY_EN=1; otherwise the frame is complete and the FSM returns to IDLE.
  - PAR: the sampled bit is the parity bit. The frame is complete and the FSM returns to IDLE.
- Parity rule: with even parity, the XOR of the data bits and the parity bit must be 0. A mismatch sets the frame's err flag. With PARITY_EN=0, err is always 0.
- Frame completion: the word, with its err flag, is loaded into the output register on the same edge that samples the last bit. This applies in all of the following cases:
  - dout_valid=0.
  - dout_valid=1 and dout_ready=1 on that edge. The new word replaces the old one, dout_valid stays 1, and frame_cnt increments once.
  - dout_valid=1 and dout_ready=0 on that edge: the new word is discarded, dout, par_err and frame_cnt are unchanged, and overrun is set to 1.
- Handshake: on an edge with dout_valid & dout_ready and no completing frame, dout_valid clears to 0. dout and par_err hold their last values but are don't-care.
- frame_cnt increments on every load into dout, including words loaded with par_err=1. 255 wraps to 0.
- overrun clears only on rst.
- A start bit may be sampled on the edge directly after the last bit of the previous frame; there is no idle gap requirement.

## Timing

- Reset: on any edge with rst=1 the FSM goes to IDLE, the bit counter and shift register go to 0, and outputs are forced as follows:
  - dout=0, dout_valid=0, par_err=0, overrun=0, frame_cnt=0.
  - A partial frame is discarded.
  - rst has priority over sin_en and dout_ready.
- Latency: the last bit of the frame is sampled at edge N. dout, par_err, dout_valid=1 and the incremented frame_cnt are visible after edge N.
- Minimum frame time is 1 + WIDTH + PARITY_EN sampled edges. With sin_en tied high, a new word can arrive every 1+WIDTH+PARITY_EN cycles.
- Gaps in sin_en freeze the FSM, bit counter and shift register. The output handshake still proceeds during gaps.
- dout_valid does not depend combinationally on dout_ready. All outputs are registered.
- The consumer may hold dout_ready high permanently; the block then never asserts overrun.

## Test plan

- Reset, then WIDTH=3, PARITY_EN=1, sin_en=1. Send start, data 1,0,1, parity 0 → dout=3'b101, par_err=0, dout_valid=1 one cycle after the parity edge, frame_cnt=1.
- Same frame with parity bit 1 → dout=3'b101, par_err=1, dout_valid=1, frame_cnt=1, overrun=0.
- dout_ready=0. Send two back-to-back frames: 3'b011, then 3'b110 → dout stays 3'b011, overrun=1, frame_cnt=1. After dout_ready=1 for one edge → dout_valid=0; overrun remains 1.
- dout_ready=1 held, 300 back-to-back frames with random data and correct parity → every word matches, no overrun, frame_cnt=300 mod 256=44.
- sin_en toggling 1,0,0,1 through a frame carrying 3'b010 → same result as the contiguous frame: dout=3'b010, latency counted in sampled edges only.
- rst=1 for one cycle after two data bits of a frame → all outputs 0. A following complete frame 3'b111 with parity 1 → dout=3'b111, par_err=0, frame_cnt=1.
